// File: rtl/route_buffer_ms_pkg.sv
// Shared constants and types for the multi-slot route buffer.
package route_buffer_ms_pkg;

    localparam int W_FRAME_SIZE  = 16;
    localparam int IFM_DW_DEF    = 32;
    localparam int FM_DW_DEF     = 32;
    localparam int IFM_AW_DEF    = 12;
    localparam int RTE_DEPTH_DEF = 64;
    localparam int RTE_AW_DEF    = 6;

    localparam logic [1:0] RTE_IFM  = 2'b00;
    localparam logic [1:0] RTE_BUF  = 2'b01;
    localparam logic [1:0] RTE_DRAM = 2'b10;

    function automatic int slot_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ROUTE_NUM_SLOTS = 2;
    localparam int ROUTE_SLOT_W    = slot_width(ROUTE_NUM_SLOTS);

    typedef enum logic [1:0] {
        LS_IDLE,
        LS_READ,
        LS_DONE,
        LS_WAIT_LOW
    } load_state_e;

endpackage

// File: rtl/dpram_wrapper.sv
// Simple dual-port RAM: port A writes, port B reads with one cycle latency and holds dob while enb=0.
module dpram_wrapper #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          wea,
    input  logic [AW-1:0] addra,
    input  logic [DW-1:0] dia,
    input  logic          enb,
    input  logic [AW-1:0] addrb,
    output logic [DW-1:0] dob
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wea) mem[addra] <= dia;
    end

    always_ff @(posedge clk) begin
        if (enb) dob <= mem[addrb];
    end

endmodule

// File: rtl/route_load_fsm.sv
// Replay sequencer: detects the load edge, issues bank reads and presents beats with valid/ready.
module route_load_fsm
    import route_buffer_ms_pkg::*;
#(
    parameter int IFM_AW = IFM_AW_DEF,
    parameter int RTE_AW = RTE_AW_DEF,
    parameter int SLOT_W = ROUTE_SLOT_W
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    load,
    input  logic                    load_buf,
    input  logic [W_FRAME_SIZE-1:0] frame_size,
    input  logic [SLOT_W-1:0]       slot,
    input  logic [IFM_AW-1:0]       offset,
    input  logic                    rdy,
    output logic                    enb,
    output logic [RTE_AW-1:0]       rd_addr,
    output logic [SLOT_W-1:0]       rd_slot,
    output logic                    vld,
    output logic [IFM_AW-1:0]       addr,
    output logic                    done
);

    localparam logic [W_FRAME_SIZE-1:0] ONE = W_FRAME_SIZE'(1);

    load_state_e             state, state_nxt;
    logic                    load_d, start_p0;
    logic [W_FRAME_SIZE-1:0] size_q, cnt, idx_p1;
    logic                    vld_p1, issue, accept, last_beat;

    // Load request is registered once so the start decision sees a clean edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            load_d   <= 1'b0;
            start_p0 <= 1'b0;
        end else begin
            load_d   <= load;
            start_p0 <= load & ~load_d & load_buf;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= LS_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LS_IDLE:     if (start_p0) state_nxt = (frame_size == '0) ? LS_DONE : LS_READ;
            LS_READ:     if (last_beat) state_nxt = LS_DONE;
            LS_DONE:     state_nxt = LS_WAIT_LOW;
            LS_WAIT_LOW: state_nxt = LS_WAIT_LOW;
            default:     state_nxt = LS_IDLE;
        endcase
        if (!load) state_nxt = LS_IDLE;
    end

    always_comb begin
        issue = (state == LS_READ) && load && (cnt < size_q) && (!vld_p1 || rdy);
        done  = (state == LS_DONE);
    end

    assign accept    = vld_p1 & rdy;
    assign last_beat = accept && ((idx_p1 + ONE) == size_q);

    // Bank output lands one cycle after issue; idx_p1 tags the beat currently on the bus.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt     <= '0;
            size_q  <= '0;
            rd_slot <= '0;
            idx_p1  <= '0;
            vld_p1  <= 1'b0;
        end else if (state == LS_IDLE || !load) begin
            cnt    <= '0;
            vld_p1 <= 1'b0;
            if (state == LS_IDLE && start_p0 && load) begin
                size_q  <= frame_size;
                rd_slot <= slot;
            end
        end else if (issue) begin
            cnt    <= cnt + ONE;
            idx_p1 <= cnt;
            vld_p1 <= 1'b1;
        end else if (accept) begin
            vld_p1 <= 1'b0;
        end
    end

    assign enb     = issue;
    assign rd_addr = RTE_AW'(cnt);
    assign vld     = vld_p1;
    assign addr    = vld_p1 ? (offset + IFM_AW'(idx_p1)) : '0;

endmodule

// File: rtl/route_buffer_ms.sv
// Multi-slot route buffer: saves postprocessor output into a bank or the IFM buffer, replays a bank.
module route_buffer_ms
    import route_buffer_ms_pkg::*;
#(
    parameter int IFM_DW    = IFM_DW_DEF,
    parameter int OFM_DW    = FM_DW_DEF,
    parameter int FM_DW     = FM_DW_DEF,
    parameter int IFM_AW    = IFM_AW_DEF,
    parameter int RTE_DEPTH = RTE_DEPTH_DEF,
    parameter int RTE_AW    = RTE_AW_DEF,
    parameter int NUM_SLOTS = ROUTE_NUM_SLOTS,
    parameter int SLOT_W    = ROUTE_SLOT_W
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [W_FRAME_SIZE-1:0] q_frame_size,
    input  logic                    q_route_save,
    input  logic                    q_route_load,
    input  logic [1:0]              q_route_loc,
    input  logic [SLOT_W-1:0]       q_route_slot,
    input  logic [IFM_AW-1:0]       q_route_offset,
    input  logic                    pp_data_vld,
    input  logic [OFM_DW-1:0]       pp_data,
    input  logic [IFM_AW-1:0]       pp_addr,
    output logic                    rte_ifm_vld,
    output logic                    rte_ifm_write_vld,
    output logic [IFM_AW-1:0]       rte_ifm_write_addr,
    output logic [IFM_DW-1:0]       rte_ifm_write_data,
    output logic                    rte_buf_load_vld,
    input  logic                    rte_buf_load_rdy,
    output logic [IFM_AW-1:0]       rte_buf_load_addr,
    output logic [FM_DW-1:0]        rte_buf_load_data,
    output logic                    rte_buf_load_done,
    output logic                    rte_buf_ovf
);

    logic                 save_ifm, save_buf, addr_ok, save_d, ovf_q;
    logic                 rd_en;
    logic [RTE_AW-1:0]    rd_addr;
    logic [SLOT_W-1:0]    rd_slot;
    logic [NUM_SLOTS-1:0] wea_slot, enb_slot;
    logic [FM_DW-1:0]     dob [NUM_SLOTS];

    assign save_ifm = q_route_save && (q_route_loc == RTE_IFM);
    assign save_buf = q_route_save && (q_route_loc == RTE_BUF);
    assign addr_ok  = pp_addr < IFM_AW'(RTE_DEPTH);

    assign rte_ifm_vld        = save_ifm;
    assign rte_ifm_write_vld  = save_ifm & pp_data_vld;
    assign rte_ifm_write_addr = save_ifm ? (q_route_offset + pp_addr) : '0;
    assign rte_ifm_write_data = save_ifm ? IFM_DW'(pp_data) : '0;

    // Overflow is sticky across a save session and re-armed when save mode is entered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            save_d <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            save_d <= q_route_save;
            if (q_route_save && !save_d)            ovf_q <= 1'b0;
            if (save_buf && pp_data_vld && !addr_ok) ovf_q <= 1'b1;
        end
    end

    assign rte_buf_ovf = ovf_q;

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_bank
        assign wea_slot[s] = save_buf && pp_data_vld && addr_ok && (q_route_slot == SLOT_W'(s));
        assign enb_slot[s] = rd_en && (rd_slot == SLOT_W'(s));

        dpram_wrapper #(
            .DEPTH(RTE_DEPTH),
            .AW   (RTE_AW),
            .DW   (FM_DW)
        ) u_bank (
            .clk  (clk),
            .wea  (wea_slot[s]),
            .addra(RTE_AW'(pp_addr)),
            .dia  (FM_DW'(pp_data)),
            .enb  (enb_slot[s]),
            .addrb(rd_addr),
            .dob  (dob[s])
        );
    end

    route_load_fsm #(
        .IFM_AW(IFM_AW),
        .RTE_AW(RTE_AW),
        .SLOT_W(SLOT_W)
    ) u_fsm (
        .clk       (clk),
        .rstn      (rstn),
        .load      (q_route_load),
        .load_buf  (q_route_loc == RTE_BUF),
        .frame_size(q_frame_size),
        .slot      (q_route_slot),
        .offset    (q_route_offset),
        .rdy       (rte_buf_load_rdy),
        .enb       (rd_en),
        .rd_addr   (rd_addr),
        .rd_slot   (rd_slot),
        .vld       (rte_buf_load_vld),
        .addr      (rte_buf_load_addr),
        .done      (rte_buf_load_done)
    );

    assign rte_buf_load_data = rte_buf_load_vld ? dob[rd_slot] : '0;

endmodule

// File: tb/tb_route_buffer_ms.sv
// Randomized bench for route_buffer_ms against a bank-contents model and a beat-order scoreboard.
module tb_route_buffer_ms;
    import route_buffer_ms_pkg::*;

    localparam int IFM_AW = 12;
    localparam int FM_DW  = 32;
    localparam int DEPTH  = 64;

    logic                    clk = 1'b0;
    logic                    rstn = 1'b0;
    logic [W_FRAME_SIZE-1:0] q_frame_size = '0;
    logic                    q_route_save = 1'b0;
    logic                    q_route_load = 1'b0;
    logic [1:0]              q_route_loc = 2'b00;
    logic [0:0]              q_route_slot = '0;
    logic [IFM_AW-1:0]       q_route_offset = '0;
    logic                    pp_data_vld = 1'b0;
    logic [FM_DW-1:0]        pp_data = '0;
    logic [IFM_AW-1:0]       pp_addr = '0;
    logic                    rte_ifm_vld, rte_ifm_write_vld;
    logic [IFM_AW-1:0]       rte_ifm_write_addr;
    logic [FM_DW-1:0]        rte_ifm_write_data;
    logic                    rte_buf_load_vld;
    logic                    rte_buf_load_rdy = 1'b0;
    logic [IFM_AW-1:0]       rte_buf_load_addr;
    logic [FM_DW-1:0]        rte_buf_load_data;
    logic                    rte_buf_load_done, rte_buf_ovf;

    always #5 clk = ~clk;

    route_buffer_ms #(
        .IFM_DW(FM_DW), .OFM_DW(FM_DW), .FM_DW(FM_DW), .IFM_AW(IFM_AW),
        .RTE_DEPTH(DEPTH), .RTE_AW(6), .NUM_SLOTS(2), .SLOT_W(1)
    ) dut (
        .clk(clk), .rstn(rstn), .q_frame_size(q_frame_size), .q_route_save(q_route_save),
        .q_route_load(q_route_load), .q_route_loc(q_route_loc), .q_route_slot(q_route_slot),
        .q_route_offset(q_route_offset), .pp_data_vld(pp_data_vld), .pp_data(pp_data),
        .pp_addr(pp_addr), .rte_ifm_vld(rte_ifm_vld), .rte_ifm_write_vld(rte_ifm_write_vld),
        .rte_ifm_write_addr(rte_ifm_write_addr), .rte_ifm_write_data(rte_ifm_write_data),
        .rte_buf_load_vld(rte_buf_load_vld), .rte_buf_load_rdy(rte_buf_load_rdy),
        .rte_buf_load_addr(rte_buf_load_addr), .rte_buf_load_data(rte_buf_load_data),
        .rte_buf_load_done(rte_buf_load_done), .rte_buf_ovf(rte_buf_ovf)
    );

    int               n_vec = 0;
    int               n_err = 0;
    logic [FM_DW-1:0] model_mem [2][DEPTH];
    logic             model_ovf = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic save_begin(input logic [1:0] loc);
        q_route_save = 1'b1;
        q_route_loc  = loc;
        pp_data_vld  = 1'b0;
        model_ovf    = 1'b0;
        tick();
    endtask

    task automatic save_end();
        q_route_save = 1'b0;
        pp_data_vld  = 1'b0;
        tick();
    endtask

    task automatic save_word(input int slot, input int a, input logic [FM_DW-1:0] d);
        q_route_slot = 1'(slot);
        pp_addr      = IFM_AW'(a);
        pp_data      = d;
        pp_data_vld  = 1'b1;
        if (q_route_loc == RTE_BUF) begin
            if (a < DEPTH) model_mem[slot][a] = d;
            else           model_ovf = 1'b1;
        end
        tick();
        pp_data_vld = 1'b0;
    endtask

    // Replays one slot; rmode 0: rdy high, 1: rdy 1,0,0 repeating, 2: random. abort_at>=0 drops load after that many beats.
    task automatic run_load(input int slot, input int size, input logic [IFM_AW-1:0] off,
                            input int rmode, input int abort_at);
        int               k, done_cnt, last_acc, drop_cyc, done_cyc;
        bit               dropped, finished, prev_vld, prev_rdy;
        logic [FM_DW-1:0]  prev_data;
        logic [IFM_AW-1:0] prev_addr, exp_addr;
        k = 0; done_cnt = 0; last_acc = -10; drop_cyc = -1; done_cyc = -1;
        dropped = 0; finished = 0; prev_vld = 0; prev_rdy = 0;
        prev_data = '0; prev_addr = '0;
        q_route_slot   = 1'(slot);
        q_frame_size   = W_FRAME_SIZE'(size);
        q_route_offset = off;
        q_route_loc    = RTE_BUF;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 0) q_route_load = 1'b1;
            case (rmode)
                0:       rte_buf_load_rdy = 1'b1;
                1:       rte_buf_load_rdy = (cyc % 3 == 0);
                default: rte_buf_load_rdy = 1'($urandom_range(0, 1));
            endcase
            if (abort_at >= 0 && !dropped && k == abort_at) begin
                q_route_load     = 1'b0;
                rte_buf_load_rdy = 1'b0;
                dropped          = 1;
                drop_cyc         = cyc;
            end
            @(negedge clk);
            if (prev_vld && !prev_rdy && !dropped) begin
                check("stall_vld", rte_buf_load_vld, 1'b1);
                check("stall_data", rte_buf_load_data, prev_data);
                check("stall_addr", rte_buf_load_addr, prev_addr);
            end
            if (!rte_buf_load_vld) check("idle_data", rte_buf_load_data, '0);
            if (dropped && cyc > drop_cyc) check("abort_vld", rte_buf_load_vld, 1'b0);
            if (done_cyc >= 0) check("wait_vld", rte_buf_load_vld, 1'b0);
            if (rte_buf_load_vld && rte_buf_load_rdy) begin
                exp_addr = off + IFM_AW'(k);
                check("beat_data", rte_buf_load_data, model_mem[slot][k % DEPTH]);
                check("beat_addr", rte_buf_load_addr, exp_addr);
                k++;
                last_acc = cyc;
            end
            if (rte_buf_load_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            prev_vld  = rte_buf_load_vld;
            prev_rdy  = rte_buf_load_rdy;
            prev_data = rte_buf_load_data;
            prev_addr = rte_buf_load_addr;
            if (dropped && cyc >= drop_cyc + 3) finished = 1;
            if (!dropped && done_cyc >= 0 && cyc >= done_cyc + 3) finished = 1;
        end
        if (abort_at >= 0) begin
            check("abort_done", done_cnt, 0);
            check("abort_beats", k, abort_at);
        end else begin
            check("done_cnt", done_cnt, 1);
            check("beat_cnt", k, size);
            check("done_cyc", done_cyc, (size == 0) ? 2 : last_acc + 1);
        end
        q_route_load     = 1'b0;
        rte_buf_load_rdy = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        logic [IFM_AW-1:0] off, a;
        logic [FM_DW-1:0]  d;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ifm_vld", rte_ifm_vld, 1'b0);
        check("rst_ifm_wvld", rte_ifm_write_vld, 1'b0);
        check("rst_ifm_addr", rte_ifm_write_addr, '0);
        check("rst_ifm_data", rte_ifm_write_data, '0);
        check("rst_vld", rte_buf_load_vld, 1'b0);
        check("rst_addr", rte_buf_load_addr, '0);
        check("rst_data", rte_buf_load_data, '0);
        check("rst_done", rte_buf_load_done, 1'b0);
        check("rst_ovf", rte_buf_ovf, 1'b0);
        rstn = 1'b1;
        tick();

        // Fill both banks; slot 1 words 0..7 carry i*3.
        save_begin(RTE_BUF);
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < DEPTH; i++)
                save_word(s, i, (s == 1 && i < 8) ? FM_DW'(i * 3) : FM_DW'($urandom));
        @(negedge clk);
        check("fill_ovf", rte_buf_ovf, 1'b0);
        save_end();

        // Save-IFM pass-through, must not touch the banks.
        save_begin(RTE_IFM);
        q_route_offset = 12'h100; q_route_slot = 1'b0; pp_addr = 12'd5; pp_data = 32'hA5; pp_data_vld = 1'b1;
        @(negedge clk);
        check("ifm_vld", rte_ifm_vld, 1'b1);
        check("ifm_wvld", rte_ifm_write_vld, 1'b1);
        check("ifm_addr", rte_ifm_write_addr, 12'h105);
        check("ifm_data", rte_ifm_write_data, 32'hA5);
        for (int i = 0; i < 6; i++) begin
            tick();
            off = IFM_AW'($urandom); a = IFM_AW'($urandom); d = $urandom;
            q_route_offset = off; pp_addr = a; pp_data = d; pp_data_vld = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("ifm_rnd_addr", rte_ifm_write_addr, IFM_AW'(off + a));
            check("ifm_rnd_data", rte_ifm_write_data, d);
            check("ifm_rnd_wvld", rte_ifm_write_vld, pp_data_vld);
        end
        check("ifm_ovf", rte_buf_ovf, 1'b0);
        save_end();

        run_load(1, 8, 12'h040, 0, -1);
        run_load(0, 8, IFM_AW'($urandom), 1, -1);
        run_load(0, 0, 12'h020, 0, -1);

        // Out-of-range save sets ovf and leaves word 0 intact; a new save session clears it.
        save_begin(RTE_BUF);
        save_word(1, DEPTH, 32'hDEAD_BEEF);
        @(negedge clk);
        check("ovf_set", rte_buf_ovf, model_ovf);
        save_word(1, 3, 32'h1234_5678);
        @(negedge clk);
        check("ovf_sticky", rte_buf_ovf, 1'b1);
        save_end();
        save_begin(RTE_BUF);
        @(negedge clk);
        check("ovf_clear", rte_buf_ovf, model_ovf);
        save_end();
        run_load(1, 4, 12'h300, 0, -1);

        run_load(0, 16, 12'hFF8, 0, 5);
        run_load(0, 16, 12'hFF8, 0, -1);

        for (int it = 0; it < 6; it++) begin
            save_begin(RTE_BUF);
            for (int j = 0; j < 4; j++) save_word($urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom);
            save_end();
            run_load($urandom_range(0, 1), $urandom_range(1, DEPTH), IFM_AW'($urandom), 2, -1);
        end

        // Asynchronous reset in the middle of a replay.
        q_route_slot = 1'b1; q_frame_size = 16; q_route_offset = 12'h010; q_route_loc = RTE_BUF;
        q_route_load = 1'b1; rte_buf_load_rdy = 1'b1;
        repeat (6) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check("arst_vld", rte_buf_load_vld, 1'b0);
        check("arst_data", rte_buf_load_data, '0);
        check("arst_addr", rte_buf_load_addr, '0);
        check("arst_done", rte_buf_load_done, 1'b0);
        check("arst_ovf", rte_buf_ovf, 1'b0);
        q_route_load = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        @(negedge clk);
        check("post_rst_vld", rte_buf_load_vld, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
